// File: rtl/conv_pkg.sv
// Shared definitions for the convolution layer sequencer: FSM states and default map dimensions.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        STREAM,
        DRAIN,
        NEXT,
        FIN
    } state_e;

    localparam int DEF_IMG_W     = 96;
    localparam int DEF_IMG_H     = 96;
    localparam int DEF_OUT_W     = 88;
    localparam int DEF_OUT_H     = 88;
    localparam int DEF_NUM_CH    = 13;
    localparam int DEF_DRAIN_MAX = 2048;
    localparam int NUM_OUT       = DEF_OUT_W * DEF_OUT_H;

    localparam int RD_AW  = 14;
    localparam int SAVE_W = 13;
    localparam int CH_W   = 4;

endpackage

// File: rtl/conv_layer_seq.sv
// Sequences one convolution layer: streams the input map once per output channel and writes engine results.
// Optional drain watchdog enabled by defining CONV_SEQ_WATCHDOG_EN.
module conv_layer_seq
    import conv_pkg::*;
#(
    parameter int IMG_W     = DEF_IMG_W,
    parameter int IMG_H     = DEF_IMG_H,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int OUT_H     = DEF_OUT_H,
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int DRAIN_MAX = DEF_DRAIN_MAX
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic                     req,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     rd_en,
    output logic [RD_AW-1:0]         rd_addr,
    input  logic signed [15:0]       pix_in,
    output logic                     eng_clr,
    output logic                     eng_start,
    output logic signed [15:0]       eng_map,
    input  logic                     eng_save,
    input  logic signed [15:0]       eng_data,
    output logic                     wr_en,
    output logic [CH_W-1:0]          wr_ch,
    output logic [SAVE_W-1:0]        wr_addr,
    output logic [15:0]              wr_data
);

    localparam int                PIX_CNT   = IMG_W * IMG_H;
    localparam int                OUT_CNT   = OUT_W * OUT_H;
    localparam logic [RD_AW-1:0]  LAST_ADDR = RD_AW'(PIX_CNT - 1);
    localparam logic [SAVE_W-1:0] SAVE_FULL = SAVE_W'(OUT_CNT);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);

    state_e              state_q, state_d;
    logic [RD_AW-1:0]    rd_addr_q, rd_addr_d;
    logic [SAVE_W-1:0]   save_cnt_q, save_cnt_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic                started_q, started_d;
    logic                in_run;
    logic                save_full;
    logic                save_ok;
    logic                timeout;

`ifdef CONV_SEQ_WATCHDOG_EN
    localparam int DW = $clog2(DRAIN_MAX + 2);
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic          err_q, err_d;
`endif

    // started_q marks that read data is arriving, one cycle behind the first rd_en
    always_comb begin
        in_run     = (state_q == STREAM) || (state_q == DRAIN);
        save_full  = (save_cnt_q == SAVE_FULL);
        save_ok    = in_run && eng_save && !save_full;
`ifdef CONV_SEQ_WATCHDOG_EN
        timeout    = (state_q == DRAIN) && !save_full && (drain_cnt_q == DW'(DRAIN_MAX));
`else
        timeout    = 1'b0;
`endif

        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        save_cnt_d = save_cnt_q + {{(SAVE_W-1){1'b0}}, save_ok};
        ch_d       = ch_q;
        started_d  = started_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    ch_d    = '0;
                    state_d = CLR;
                end
            end
            CLR: begin
                rd_addr_d  = '0;
                save_cnt_d = '0;
                started_d  = 1'b0;
                state_d    = STREAM;
            end
            STREAM: begin
                started_d = 1'b1;
                if (save_full) begin
                    state_d = NEXT;
                end else if (rd_addr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                end else begin
                    rd_addr_d = rd_addr_q + 1'b1;
                end
            end
            DRAIN: begin
                if (save_full) begin
                    state_d = NEXT;
                end else if (timeout) begin
                    state_d = FIN;
                end
            end
            NEXT: begin
                save_cnt_d = '0;
                if (ch_q < LAST_CH) begin
                    ch_d    = ch_q + 1'b1;
                    state_d = CLR;
                end else begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy      = (state_q != IDLE);
        done      = (state_q == FIN);
        rd_en     = (state_q == STREAM);
        rd_addr   = rd_addr_q;
        eng_clr   = (state_q == CLR);
        eng_start = in_run && started_q && !save_full && !timeout;
        eng_map   = ((state_q == STREAM) && started_q) ? pix_in : 16'sd0;
        wr_en     = save_ok;
        wr_ch     = ch_q;
        wr_addr   = save_cnt_q;
        wr_data   = save_ok ? $unsigned(eng_data) : 16'd0;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_addr_q  <= '0;
            save_cnt_q <= '0;
            ch_q       <= '0;
            started_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            save_cnt_q <= save_cnt_d;
            ch_q       <= ch_d;
            started_q  <= started_d;
        end
    end

`ifdef CONV_SEQ_WATCHDOG_EN
    // Counts cycles spent in DRAIN; err stays set until reset
    always_comb begin
        drain_cnt_d = (state_q == DRAIN) ? drain_cnt_q + 1'b1 : '0;
        err_d       = err_q || timeout;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            drain_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            drain_cnt_q <= drain_cnt_d;
            err_q       <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_conv_layer_seq.sv
// Directed testbench for conv_layer_seq using a reduced 12x12 -> 10x10 map with 13 channels.
module tb_conv_layer_seq;

    localparam int IMG_W     = 12;
    localparam int IMG_H     = 12;
    localparam int OUT_W     = 10;
    localparam int OUT_H     = 10;
    localparam int NUM_CH    = 13;
    localparam int DRAIN_MAX = 80;
    localparam int PIX       = IMG_W * IMG_H;
    localparam int NOUT      = OUT_W * OUT_H;

    logic               clk_in;
    logic               rst_n;
    logic               req;
    logic               busy, done, err;
    logic               rd_en;
    logic [13:0]        rd_addr;
    logic signed [15:0] pix_in;
    logic               eng_clr, eng_start;
    logic signed [15:0] eng_map;
    logic               eng_save;
    logic signed [15:0] eng_data;
    logic               wr_en;
    logic [3:0]         wr_ch;
    logic [12:0]        wr_addr;
    logic [15:0]        wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    int eng_quota   = NOUT;
    bit eng_free    = 1'b0;
    int eng_emitted = 0;
    int eng_run     = 0;
    bit eng_go      = 1'b0;

    typedef struct {
        int ch;
        int addr;
        int data;
    } wr_rec_t;

    wr_rec_t wr_q[$];
    int cyc         = 0;
    int done_count  = 0;
    int clr_count   = 0;
    int save0_count = 0;
    int last_rd_cyc = 0;
    int done_cyc    = 0;

    conv_layer_seq #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .OUT_W(OUT_W), .OUT_H(OUT_H),
        .NUM_CH(NUM_CH), .DRAIN_MAX(DRAIN_MAX)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .req(req),
        .busy(busy), .done(done), .err(err),
        .rd_en(rd_en), .rd_addr(rd_addr), .pix_in(pix_in),
        .eng_clr(eng_clr), .eng_start(eng_start), .eng_map(eng_map),
        .eng_save(eng_save), .eng_data(eng_data),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    function automatic logic signed [15:0] word(input int a);
        return 16'(a * 3 + 7);
    endfunction

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Input buffer with one-cycle read latency; junk value when no read was issued
    initial begin
        bit        rd_seen;
        logic [13:0] rd_a;
        pix_in = 16'sh7EEE;
        forever begin
            @(negedge clk_in);
            rd_seen = rd_en;
            rd_a    = rd_addr;
            @(posedge clk_in);
            #1;
            pix_in = rd_seen ? word(int'(rd_a)) : 16'sh7EEE;
        end
    end

    // Engine model: gated mode saves every second enabled cycle, free mode saves every cycle once started
    initial begin
        eng_save = 1'b0;
        eng_data = '0;
        forever begin
            @(posedge clk_in);
            #1;
            eng_save = 1'b0;
            if (!rst_n || eng_clr) begin
                eng_emitted = 0;
                eng_run     = 0;
                eng_go      = 1'b0;
            end else begin
                if (eng_start) begin
                    eng_go  = 1'b1;
                    eng_run = eng_run + 1;
                end
                if (eng_go && eng_emitted < eng_quota &&
                    (eng_free || (eng_start && (eng_run % 2 == 0)))) begin
                    eng_save    = 1'b1;
                    eng_data    = 16'(eng_emitted * 5 + 1);
                    eng_emitted = eng_emitted + 1;
                end
            end
        end
    end

    always @(negedge clk_in) begin
        cyc = cyc + 1;
        if (wr_en) wr_q.push_back('{int'(wr_ch), int'(wr_addr), int'(wr_data)});
        if (done) begin
            done_count = done_count + 1;
            done_cyc   = cyc;
        end
        if (eng_clr) clr_count = clr_count + 1;
        if (rd_en) last_rd_cyc = cyc;
        if (eng_save && busy && wr_ch == 4'd0) save0_count = save0_count + 1;
    end

    task automatic do_reset();
        @(negedge clk_in);
        rst_n = 1'b0;
        req   = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);
        wr_q.delete();
        done_count  = 0;
        clr_count   = 0;
        save0_count = 0;
    endtask

    task automatic pulse_req();
        req = 1'b1;
        @(negedge clk_in);
        req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 1'b0;
        repeat (3) @(negedge clk_in);
        n_checks++;
        if ({busy, done, err, rd_en, eng_clr, eng_start, wr_en} !== 7'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got %b, expected 0000000",
                     {busy, done, err, rd_en, eng_clr, eng_start, wr_en});
        end
        n_checks++;
        if (rd_addr !== 14'd0 || wr_addr !== 13'd0 || wr_ch !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_counters: got rd_addr=%0d wr_addr=%0d wr_ch=%0d, expected 0 0 0",
                     rd_addr, wr_addr, wr_ch);
        end
        n_checks++;
        if (eng_map !== 16'sd0 || wr_data !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_data: got eng_map=%0d wr_data=%0d, expected 0 0", eng_map, wr_data);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk_in);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_hold: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_layer();
        int t, drain_cyc, drain_bad, n;
        do_reset();
        eng_quota = NOUT;
        eng_free  = 1'b0;
        @(negedge clk_in);
        pulse_req();
        n_checks++;
        if (eng_clr !== 1'b1 || eng_start !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL clr_cycle: got clr=%b start=%b busy=%b, expected 1 0 1", eng_clr, eng_start, busy);
        end
        @(negedge clk_in);
        n_checks++;
        if (rd_en !== 1'b1 || rd_addr !== 14'd0 || eng_start !== 1'b0 || eng_clr !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL first_read: got rd_en=%b addr=%0d start=%b clr=%b, expected 1 0 0 0",
                     rd_en, rd_addr, eng_start, eng_clr);
        end
        @(negedge clk_in);
        n_checks++;
        if (eng_start !== 1'b1 || eng_map !== word(0) || rd_addr !== 14'd1) begin
            n_fail++;
            $display("[TB] FAIL first_pixel: got start=%b map=%0d addr=%0d, expected 1 %0d 1",
                     eng_start, eng_map, rd_addr, word(0));
        end
        t = 0; drain_cyc = 0; drain_bad = 0;
        while (done_count == 0 && t < 20000) begin
            @(negedge clk_in);
            if (busy && !rd_en && eng_start) begin
                drain_cyc++;
                if (eng_map !== 16'sd0) drain_bad++;
            end
            t++;
        end
        n_checks++;
        if (done_count == 0) begin
            n_fail++;
            $display("[TB] FAIL layer_timeout: got no done after %0d cycles, expected done", t);
        end
        repeat (3) @(negedge clk_in);
        n_checks++;
        if (drain_cyc == 0 || drain_bad != 0) begin
            n_fail++;
            $display("[TB] FAIL drain_map: got %0d drain cycles with %0d nonzero maps, expected >0 and 0",
                     drain_cyc, drain_bad);
        end
        n_checks++;
        if (wr_q.size() != NUM_CH * NOUT) begin
            n_fail++;
            $display("[TB] FAIL write_total: got %0d, expected %0d", wr_q.size(), NUM_CH * NOUT);
        end
        n = (wr_q.size() < NUM_CH * NOUT) ? wr_q.size() : NUM_CH * NOUT;
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (wr_q[i].ch != i / NOUT || wr_q[i].addr != i % NOUT || wr_q[i].data != (i % NOUT) * 5 + 1) begin
                n_fail++;
                $display("[TB] FAIL write_seq[%0d]: got ch=%0d addr=%0d data=%0d, expected ch=%0d addr=%0d data=%0d",
                         i, wr_q[i].ch, wr_q[i].addr, wr_q[i].data, i / NOUT, i % NOUT, (i % NOUT) * 5 + 1);
            end
        end
        n_checks++;
        if (done_count != 1 || clr_count != NUM_CH || err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL layer_end: got done=%0d clr=%0d err=%b busy=%b, expected 1 %0d 0 0",
                     done_count, clr_count, err, busy, NUM_CH);
        end
    endtask

    task automatic test_req_while_busy();
        int t, prev, bad, clr_before;
        do_reset();
        eng_quota = NOUT;
        eng_free  = 1'b0;
        @(negedge clk_in);
        pulse_req();
        t = 0;
        while (!(rd_en && rd_addr == 14'd40) && t < 400) begin
            @(negedge clk_in);
            t++;
        end
        n_checks++;
        if (!(rd_en && rd_addr == 14'd40)) begin
            n_fail++;
            $display("[TB] FAIL busy_wait: got rd_addr=%0d, expected 40", rd_addr);
        end
        clr_before = clr_count;
        req  = 1'b1;
        prev = 40;
        bad  = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_in);
            req = 1'b0;
            if (!rd_en || int'(rd_addr) != prev + 1 || eng_clr) bad++;
            prev++;
        end
        n_checks++;
        if (bad != 0 || clr_count != clr_before || busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL req_ignored: got %0d broken cycles, clr delta %0d, busy=%b, expected 0 0 1",
                     bad, clr_count - clr_before, busy);
        end
    endtask

    task automatic test_reset_mid_stream();
        int t, wc;
        do_reset();
        eng_quota = NOUT;
        eng_free  = 1'b0;
        @(negedge clk_in);
        pulse_req();
        t = 0;
        while (!(rd_en && rd_addr == 14'd50) && t < 400) begin
            @(negedge clk_in);
            t++;
        end
        rst_n = 1'b0;
        @(negedge clk_in);
        n_checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0 || wr_en !== 1'b0 || rd_addr !== 14'd0 ||
            eng_start !== 1'b0 || wr_addr !== 13'd0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset: got busy=%b rd_en=%b wr_en=%b rd_addr=%0d start=%b wr_addr=%0d, expected all 0",
                     busy, rd_en, wr_en, rd_addr, eng_start, wr_addr);
        end
        rst_n = 1'b1;
        wc = wr_q.size();
        repeat (30) @(negedge clk_in);
        n_checks++;
        if (wr_q.size() != wc || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL post_reset_quiet: got %0d extra writes busy=%b, expected 0 0", wr_q.size() - wc, busy);
        end
    endtask

    task automatic test_overrun();
        int t, ch0;
        do_reset();
        eng_quota = NOUT + 6;
        eng_free  = 1'b1;
        @(negedge clk_in);
        pulse_req();
        t = 0;
        while (done_count == 0 && t < 20000) begin
            @(negedge clk_in);
            t++;
        end
        repeat (3) @(negedge clk_in);
        ch0 = 0;
        foreach (wr_q[i]) if (wr_q[i].ch == 0) ch0++;
        n_checks++;
        if (ch0 != NOUT) begin
            n_fail++;
            $display("[TB] FAIL overrun_ch0: got %0d writes, expected %0d", ch0, NOUT);
        end
        n_checks++;
        if (save0_count != NOUT + 2) begin
            n_fail++;
            $display("[TB] FAIL overrun_pulses: got %0d saves on ch0, expected %0d", save0_count, NOUT + 2);
        end
        n_checks++;
        if (wr_q.size() <= NOUT || wr_q[NOUT - 1].addr != NOUT - 1 || wr_q[NOUT].ch != 1 || wr_q[NOUT].addr != 0) begin
            n_fail++;
            $display("[TB] FAIL overrun_next: got %0d writes, expected ch0 ending at %0d then ch1 addr 0",
                     wr_q.size(), NOUT - 1);
        end
        n_checks++;
        if (clr_count != NUM_CH || done_count != 1 || wr_q.size() != NUM_CH * NOUT) begin
            n_fail++;
            $display("[TB] FAIL overrun_layer: got clr=%0d done=%0d writes=%0d, expected %0d 1 %0d",
                     clr_count, done_count, wr_q.size(), NUM_CH, NUM_CH * NOUT);
        end
    endtask

    task automatic test_watchdog();
        int t;
        do_reset();
        eng_quota = 70;
        eng_free  = 1'b0;
        @(negedge clk_in);
        pulse_req();
`ifdef CONV_SEQ_WATCHDOG_EN
        t = 0;
        while (done_count == 0 && t < 2000) begin
            @(negedge clk_in);
            t++;
        end
        n_checks++;
        if (err !== 1'b1 || done_count != 1) begin
            n_fail++;
            $display("[TB] FAIL wdog_fire: got err=%b done=%0d, expected 1 1", err, done_count);
        end
        n_checks++;
        if (done_cyc - last_rd_cyc != DRAIN_MAX + 2) begin
            n_fail++;
            $display("[TB] FAIL wdog_timing: got %0d cycles last read to done, expected %0d",
                     done_cyc - last_rd_cyc, DRAIN_MAX + 2);
        end
        repeat (5) @(negedge clk_in);
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0 || done_count != 1 || wr_q.size() != 70) begin
            n_fail++;
            $display("[TB] FAIL wdog_sticky: got err=%b busy=%b done=%0d writes=%0d, expected 1 0 1 70",
                     err, busy, done_count, wr_q.size());
        end
`else
        repeat (PIX + 3 * DRAIN_MAX) @(negedge clk_in);
        n_checks++;
        if (busy !== 1'b1 || err !== 1'b0 || done_count != 0 || rd_en !== 1'b0 || eng_start !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL drain_wait: got busy=%b err=%b done=%0d rd_en=%b start=%b, expected 1 0 0 0 1",
                     busy, err, done_count, rd_en, eng_start);
        end
        n_checks++;
        if (wr_q.size() != 70) begin
            n_fail++;
            $display("[TB] FAIL drain_writes: got %0d, expected 70", wr_q.size());
        end
`endif
        do_reset();
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL wdog_clear: got err=%b busy=%b, expected 0 0", err, busy);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        $display("[TB] conv_layer_seq directed test start");
        test_reset();
        test_layer();
        test_req_while_busy();
        test_reset_mid_stream();
        test_overrun();
        test_watchdog();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
